// File: rtl/axi_master_cmd_if.sv
// Single-outstanding AXI4 burst master: turns one command-port request into an AW/W/B or AR/R burst.
// Optional watchdog flag (timeout_o) is built only when AXI_MASTER_TIMEOUT_EN is defined.
module axi_master_cmd_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic                  cmd_wr_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [STRB_WIDTH-1:0] wr_strb_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  done_o,
  output logic                  resp_err_o,
`ifdef AXI_MASTER_TIMEOUT_EN
  output logic                  timeout_o,
`endif
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic [7:0]            m_axi_awlen_o,
  output logic [2:0]            m_axi_awsize_o,
  output logic [1:0]            m_axi_awburst_o,
  output logic                  m_axi_awvalid_o,
  input  logic                  m_axi_awready_i,
  output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb_o,
  output logic                  m_axi_wlast_o,
  output logic                  m_axi_wvalid_o,
  input  logic                  m_axi_wready_i,
  input  logic [1:0]            m_axi_bresp_i,
  input  logic                  m_axi_bvalid_i,
  output logic                  m_axi_bready_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [7:0]            m_axi_arlen_o,
  output logic [2:0]            m_axi_arsize_o,
  output logic [1:0]            m_axi_arburst_o,
  output logic                  m_axi_arvalid_o,
  input  logic                  m_axi_arready_i,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]            m_axi_rresp_i,
  input  logic                  m_axi_rlast_i,
  input  logic                  m_axi_rvalid_i,
  output logic                  m_axi_rready_o
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic                  aw_done_q;
  logic                  w_done_q;
  logic                  awvalid_q;
  logic                  arvalid_q;
  logic                  done_q;
  logic                  resp_err_q;

  logic w_open;
  logic last_beat;
  logic w_hs;
  logic aw_hs;
  logic r_hs;
  logic wr_both_done;

  // W stays open only while beats remain, so nothing follows the wlast beat.
  assign w_open       = (state_q == S_WR) && !w_done_q;
  assign last_beat    = (beat_q == len_q);
  assign w_hs         = m_axi_wvalid_o && m_axi_wready_i;
  assign aw_hs        = awvalid_q && m_axi_awready_i;
  assign r_hs         = m_axi_rvalid_i && m_axi_rready_o;
  assign wr_both_done = (aw_done_q || aw_hs) && (w_done_q || (w_hs && last_beat));

  assign cmd_ready_o     = (state_q == S_IDLE) && !rst_i;

  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = len_q;
  assign m_axi_awsize_o  = AXI_SIZE;
  assign m_axi_awburst_o = 2'b01;
  assign m_axi_awvalid_o = awvalid_q;

  assign m_axi_wdata_o   = wr_data_i;
  assign m_axi_wstrb_o   = wr_strb_i;
  assign m_axi_wlast_o   = last_beat;
  assign m_axi_wvalid_o  = wr_valid_i && w_open;
  assign wr_ready_o      = m_axi_wready_i && w_open;

  assign m_axi_bready_o  = (state_q == S_WR_RESP);

  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = len_q;
  assign m_axi_arsize_o  = AXI_SIZE;
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arvalid_o = arvalid_q;

  assign rd_valid_o      = m_axi_rvalid_i && (state_q == S_RD_DATA);
  assign m_axi_rready_o  = rd_ready_i && (state_q == S_RD_DATA);
  assign rd_data_o       = m_axi_rdata_i;
  assign rd_last_o       = m_axi_rlast_i;

  assign done_o          = done_q;
  assign resp_err_o      = resp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            addr_q    <= cmd_addr_i;
            len_q     <= cmd_len_i;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (cmd_wr_i) begin
              state_q   <= S_WR;
              awvalid_q <= 1'b1;
            end else begin
              state_q   <= S_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) w_done_q <= 1'b1;
          end
          if (wr_both_done) state_q <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (m_axi_bvalid_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            if (m_axi_bresp_i != 2'b00) resp_err_q <= 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (m_axi_arready_i) begin
            arvalid_q <= 1'b0;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (r_hs) begin
            if (m_axi_rresp_i != 2'b00) resp_err_q <= 1'b1;
            if (m_axi_rlast_i) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             state_exit;
  logic [TMR_W-1:0] timer_q;
  logic             timeout_q;

  always_comb begin
    state_exit = 1'b0;
    case (state_q)
      S_IDLE:    state_exit = cmd_valid_i;
      S_WR:      state_exit = wr_both_done;
      S_WR_RESP: state_exit = m_axi_bvalid_i;
      S_RD_ADDR: state_exit = m_axi_arready_i;
      S_RD_DATA: state_exit = r_hs && m_axi_rlast_i;
      default:   state_exit = 1'b1;
    endcase
  end

  // Watchdog only flags a stall; the FSM keeps waiting for the slave.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else if (state_exit) begin
      timer_q <= '0;
    end else if (state_q != S_IDLE) begin
      if (timer_q != TMR_W'(TIMEOUT_CYCLES)) timer_q <= timer_q + TMR_W'(1);
      if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_axi_master_cmd_if.sv
// Randomized self-checking bench for axi_master_cmd_if; slave behaviour and expected streams
// are modelled here as plain per-burst queues and flags.
module tb_axi_master_cmd_if;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = DW / 8;
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          cmd_wr, cmd_valid, cmd_ready;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready;
  logic          done, resp_err;
`ifdef AXI_MASTER_TIMEOUT_EN
  logic          timeout;
`endif
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready;
  logic          rlast, rvalid, rready;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;

  always #5 clk = ~clk;

  axi_master_cmd_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_wr_i(cmd_wr),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .wr_data_i(wr_data), .wr_strb_i(wr_strb), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .done_o(done), .resp_err_o(resp_err),
`ifdef AXI_MASTER_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .m_axi_awaddr_o(awaddr), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
    .m_axi_awburst_o(awburst), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
    .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
    .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
    .m_axi_arburst_o(arburst), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
    .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
  );

  task automatic idle_inputs();
    cmd_addr = '0; cmd_len = '0; cmd_wr = 1'b0; cmd_valid = 1'b0;
    wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({awvalid, arvalid, wvalid, bready, rready, done, resp_err, cmd_ready} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {awvalid, arvalid, wvalid, bready, rready, done, resp_err, cmd_ready});
    end
`ifdef AXI_MASTER_TIMEOUT_EN
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_timeout: got %b want 0", timeout);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready_after: got %b want 1", cmd_ready);
    end
  endtask

  // aw_delay < 0: awready always high; otherwise awready waits aw_delay cycles after the last W beat.
  task automatic run_write(input logic [AW-1:0] addr, input logic [7:0] len, input bit rnd,
                           input int aw_delay, input logic [1:0] b_resp, input int b_delay,
                           input bit chk_tmo, input string tag);
    logic [DW-1:0] data [256];
    logic [SW-1:0] strb [256];
    int  sent = 0, cyc = 0, since_w = 0, resp_cyc = 0;
    bit  aw_seen = 0, b_seen = 0, in_wr, aw_hs;
    for (int i = 0; i <= int'(len); i++) begin
      data[i] = $urandom;
      strb[i] = SW'($urandom);
    end
    @(negedge clk);
    cmd_addr = addr; cmd_len = len; cmd_wr = 1'b1; cmd_valid = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!b_seen && cyc < 2000) begin
      wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = (sent <= int'(len)) ? data[sent] : '0;
      wr_strb  = (sent <= int'(len)) ? strb[sent] : '0;
      wready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      awready  = (aw_delay < 0) ? 1'b1 : 1'((sent > int'(len)) && (since_w >= aw_delay));
      bresp    = b_resp;
      bvalid   = aw_seen && (sent > int'(len)) && (resp_cyc >= b_delay);
      #1;
      in_wr = !(aw_seen && (sent > int'(len)));
      aw_hs = awvalid && awready;
      n_checks++;
      if (awvalid !== !aw_seen) begin
        n_fail++;
        $display("FAIL %s awvalid: got %b want %b", tag, awvalid, !aw_seen);
      end
      if (aw_hs) begin
        n_checks++;
        if ({awaddr, awlen, awsize, awburst} !== {addr, len, 3'd2, 2'b01}) begin
          n_fail++;
          $display("FAIL %s aw_fields: got %h/%h/%h/%h want %h/%h/2/1", tag,
                   awaddr, awlen, awsize, awburst, addr, len);
        end
      end
      n_checks++;
      if ({wvalid, wr_ready, bready} !==
          {wr_valid && in_wr && (sent <= int'(len)), wready && in_wr && (sent <= int'(len)), !in_wr}) begin
        n_fail++;
        $display("FAIL %s w_b_ctrl: got wvalid/wr_ready/bready=%b%b%b in_wr=%b sent=%0d",
                 tag, wvalid, wr_ready, bready, in_wr, sent);
      end
      if (wvalid && wready) begin
        n_checks++;
        if ({wdata, wstrb, wlast} !== {data[sent], strb[sent], sent == int'(len)}) begin
          n_fail++;
          $display("FAIL %s w_beat%0d: got %h/%h/%b want %h/%h/%b", tag, sent,
                   wdata, wstrb, wlast, data[sent], strb[sent], sent == int'(len));
        end
        sent++;
      end
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_early: got %b want 0", tag, done);
      end
`ifdef AXI_MASTER_TIMEOUT_EN
      if (chk_tmo) begin
        n_checks++;
        if (timeout !== (!in_wr && resp_cyc >= TO)) begin
          n_fail++;
          $display("FAIL %s timeout_cyc%0d: got %b want %b", tag, resp_cyc + 1,
                   timeout, !in_wr && resp_cyc >= TO);
        end
      end
`endif
      if (bvalid && bready) begin
        b_seen = 1;
        if (b_resp != 2'b00) exp_err = 1'b1;
      end
      if (aw_hs) aw_seen = 1;
      if (sent > int'(len)) since_w++;
      if (!in_wr) resp_cyc++;
      cyc++;
      @(negedge clk);
    end
    idle_inputs();
    if (!b_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s bound: no B handshake within %0d cycles, sent=%0d", tag, cyc, sent);
    end
    #1;
    n_checks++;
    if ({done, cmd_ready, resp_err} !== {1'b1, 1'b1, exp_err}) begin
      n_fail++;
      $display("FAIL %s completion: got done/cmd_ready/resp_err=%b%b%b want 11%b",
               tag, done, cmd_ready, resp_err, exp_err);
    end
`ifdef AXI_MASTER_TIMEOUT_EN
    if (chk_tmo) begin
      n_checks++;
      if (timeout !== 1'b1) begin
        n_fail++;
        $display("FAIL %s timeout_sticky: got %b want 1", tag, timeout);
      end
    end
`endif
    @(negedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse_width: got %b want 0", tag, done);
    end
  endtask

  // rd_mode: 0 always ready, 1 toggling every cycle, 2 random.
  task automatic run_read(input logic [AW-1:0] addr, input logic [7:0] len, input int rd_mode,
                          input bit rv_rnd, input logic [1:0] r_resp, input int ar_delay,
                          input string tag);
    logic [DW-1:0] data [256];
    int got = 0, cyc = 0;
    bit ar_seen = 0, ar_hs;
    for (int i = 0; i <= int'(len); i++) data[i] = $urandom;
    @(negedge clk);
    cmd_addr = addr; cmd_len = len; cmd_wr = 1'b0; cmd_valid = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    while (got <= int'(len) && cyc < 2000) begin
      arready  = 1'(cyc >= ar_delay);
      rd_ready = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      rvalid   = ar_seen && (rv_rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      rdata    = data[got];
      rlast    = (got == int'(len));
      rresp    = r_resp;
      #1;
      ar_hs = arvalid && arready;
      n_checks++;
      if (arvalid !== !ar_seen) begin
        n_fail++;
        $display("FAIL %s arvalid: got %b want %b", tag, arvalid, !ar_seen);
      end
      if (ar_hs) begin
        n_checks++;
        if ({araddr, arlen, arsize, arburst} !== {addr, len, 3'd2, 2'b01}) begin
          n_fail++;
          $display("FAIL %s ar_fields: got %h/%h/%h/%h want %h/%h/2/1", tag,
                   araddr, arlen, arsize, arburst, addr, len);
        end
      end
      n_checks++;
      if ({rd_valid, rready} !== {ar_seen && rvalid, ar_seen && rd_ready}) begin
        n_fail++;
        $display("FAIL %s r_ctrl: got rd_valid/rready=%b%b want %b%b", tag, rd_valid, rready,
                 ar_seen && rvalid, ar_seen && rd_ready);
      end
      if (rvalid && rready) begin
        n_checks++;
        if ({rd_data, rd_last} !== {data[got], got == int'(len)}) begin
          n_fail++;
          $display("FAIL %s r_beat%0d: got %h/%b want %h/%b", tag, got, rd_data, rd_last,
                   data[got], got == int'(len));
        end
        if (r_resp != 2'b00) exp_err = 1'b1;
        got++;
      end
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_early: got %b want 0", tag, done);
      end
      if (ar_hs) ar_seen = 1;
      cyc++;
      @(negedge clk);
    end
    idle_inputs();
    if (got <= int'(len)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s bound: got %0d of %0d beats in %0d cycles", tag, got, int'(len) + 1, cyc);
    end
    #1;
    n_checks++;
    if ({done, cmd_ready, resp_err} !== {1'b1, 1'b1, exp_err}) begin
      n_fail++;
      $display("FAIL %s completion: got done/cmd_ready/resp_err=%b%b%b want 11%b",
               tag, done, cmd_ready, resp_err, exp_err);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse_width: got %b want 0", tag, done);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    cmd_addr = 16'h0500; cmd_len = 8'd3; cmd_wr = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 32'hAAAA0000; wr_strb = 4'hF;
    wready = 1'b1; awready = 1'b0;
    @(negedge clk);
    wr_data = 32'hAAAA0001;
    rst = 1'b1;
    @(negedge clk);
    #1;
    exp_err = 1'b0;
    n_checks++;
    if ({awvalid, wvalid, wr_ready, bready, arvalid, rready, done, cmd_ready, resp_err} !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_mid_burst_outputs: got %b want 000000000",
               {awvalid, wvalid, wr_ready, bready, arvalid, rready, done, cmd_ready, resp_err});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, wvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_burst_idle: got cmd_ready/wvalid=%b want 10", {cmd_ready, wvalid});
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] len;
      len = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        run_write(AW'($urandom), len, 1'b1, $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 5)),
                  $urandom_range(0, 3) == 0 ? 2'b11 : 2'b00, int'($urandom_range(0, 3)), 1'b0, "rand_wr");
      else
        run_read(AW'($urandom), len, 2, 1'b1, $urandom_range(0, 3) == 0 ? 2'b10 : 2'b00,
                 int'($urandom_range(0, 4)), "rand_rd");
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    run_write(16'h0100, 8'd3, 1'b0, -1, 2'b00, 0, 1'b0, "wr_basic");
    run_read(16'h0040, 8'd0, 0, 1'b0, 2'b10, 0, "rd_err_single");
    run_write(16'h0200, 8'd5, 1'b1, 10, 2'b00, 0, 1'b0, "wr_aw_late");
    run_write(16'h0280, 8'd0, 1'b0, 3, 2'b00, 2, 1'b0, "wr_len0");
    test_reset();
    run_read(16'h0300, 8'd7, 1, 1'b0, 2'b00, 2, "rd_toggle");
    test_random();
    test_reset();
    test_reset_mid_burst();
    run_write(16'h0600, 8'd2, 1'b0, -1, 2'b00, 0, 1'b0, "wr_after_rst");
`ifdef AXI_MASTER_TIMEOUT_EN
    test_reset();
    run_write(16'h0700, 8'd1, 1'b0, -1, 2'b00, 20, 1'b1, "wr_timeout");
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_master_cmd_if.md
AXI_MASTER_CMD_IF -- requirements
Module: axi_master_cmd_if

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data bus width in bits; ADDR_WIDTH, default 16, address width; STRB_WIDTH, default DATA_WIDTH/8, strobe width; TIMEOUT_CYCLES, default 1024, watchdog limit.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cmd_addr/cmd_len/cmd_wr  in  ADDR_WIDTH/8/1  burst start address, beats-1, 1=write 0=read.
REQ-005 cmd_valid in 1, cmd_ready out 1  command handshake.
REQ-006 wr_data/wr_strb  in  DATA_WIDTH/STRB_WIDTH  write beat payload; wr_valid in 1, wr_ready out 1.
REQ-007 rd_data out DATA_WIDTH, rd_last out 1, rd_valid out 1, rd_ready in 1  read beat stream.
REQ-008 done  out  1  one-cycle pulse at burst completion.
REQ-009 resp_err  out  1  sticky flag, any non-OKAY BRESP/RRESP.
REQ-010 timeout  out  1  sticky watchdog flag; exists only with AXI_MASTER_TIMEOUT_EN.
REQ-011 m_axi_aw{addr,len,size,burst,valid} out, m_axi_awready in  AXI4 write address channel.
REQ-012 m_axi_w{data,strb,last,valid} out, m_axi_wready in  AXI4 write data channel.
REQ-013 m_axi_b{resp,valid} in, m_axi_bready out  AXI4 write response channel.
REQ-014 m_axi_ar{addr,len,size,burst,valid} out, m_axi_arready in  AXI4 read address channel.
REQ-015 m_axi_r{data,resp,last,valid} in, m_axi_rready out  AXI4 read data channel.

Function
REQ-016 FSM states SHALL be IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA.
REQ-017 cmd_ready SHALL be 1 only in IDLE; accept on cmd_valid&&cmd_ready latches addr/len, moves to WR or RD_ADDR next cycle.
REQ-018 awsize/arsize SHALL equal log2(STRB_WIDTH); awburst/arburst SHALL be 2'b01 (INCR); len SHALL equal latched cmd_len.
REQ-019 In WR, awvalid SHALL assert from first WR cycle and hold until awready; AW and W progress independently; W beats may complete before AW.
REQ-020 m_axi_wvalid = wr_valid && WR && beats remaining; wr_ready = m_axi_wready under same qualifier; data/strb pass combinationally.
REQ-021 An 8-bit beat counter SHALL count W handshakes; m_axi_wlast=1 when counter equals latched len; no W beats after last.
REQ-022 WR SHALL exit to WR_RESP in the cycle after both AW and last-W handshakes have occurred (same cycle allowed).
REQ-023 m_axi_bready SHALL be 1 only in WR_RESP; on bvalid go IDLE, pulse done, set resp_err if bresp!=2'b00.
REQ-024 RD_ADDR SHALL hold arvalid until arready, then enter RD_DATA.
REQ-025 In RD_DATA: rd_valid=m_axi_rvalid, m_axi_rready=rd_ready, rd_data/rd_last pass-through; rresp!=0 on any handshake sets resp_err; handshake with rlast returns IDLE, pulses done.
REQ-026 One burst outstanding at a time; no 4 KB boundary check (caller's duty); cmd_len=0 gives single beat with wlast on first beat.

Reset
REQ-027 On rst: state IDLE; awvalid, arvalid, wvalid, bready, rready, done, resp_err, timeout all 0; counters 0; cmd_ready 0 during rst cycle, 1 in the cycle after.
REQ-028 rst mid-burst SHALL abandon the burst immediately; no completion of outstanding AXI traffic.

Configuration
REQ-029 With AXI_MASTER_TIMEOUT_EN defined: counter clears on every state change, increments each non-IDLE cycle; reaching TIMEOUT_CYCLES sets sticky timeout (cleared only by rst); FSM keeps waiting, no abort.
REQ-030 Without AXI_MASTER_TIMEOUT_EN: no counter, no timeout port.

Verification
REQ-031 Write cmd addr=0x100 len=3, awready/wready always 1, bresp=0 -> awaddr=0x100 awlen=3 awsize=2, 4 W beats, wlast on 4th, done pulse, resp_err=0.
REQ-032 Read len=0 addr=0x40, rresp=2'b10 -> single beat rd_last=1, done pulse, resp_err=1 and stays 1.
REQ-033 Write with wready random and awready delayed 10 cycles after all W beats -> bready only after AW handshake; data order preserved.
REQ-034 Read len=7 with rd_ready toggling every cycle -> 8 beats, rready mirrors rd_ready, no beat lost or duplicated.
REQ-035 rst asserted during beat 2 of 4-beat write -> next cycle all valids 0, state IDLE, cmd_ready=1 after rst drops.
REQ-036 With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, bvalid withheld 20 cycles -> timeout=1 at cycle 16 of WR_RESP; later bvalid completes burst normally.
